act_buffer_loader: RTL and testbench

Upstream feeder for the ping/pong activation buffer. Accepts a valid/ready stream of IN_W-bit host words and packs WPR = TM*8/IN_W consecutive words into one TM*8-bit row. Writes each packed row into the current write bank, commits a bank after cfg_rows rows, then flips to the other bank. Tracks per-bank full status so the array side only reads committed banks and releases them when done.

---
 rtl/act_buffer_loader.sv | 95 +++++++++
 tb/tb_act_buffer_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/act_buffer_loader.sv
// act_buffer_loader: packs IN_W-bit stream words into TM*8-bit rows and fills a
// ping/pong activation buffer, tracking which bank holds a committed tile.
module act_buffer_loader #(
   parameter int TM = 128,
   parameter int ADDR_WIDTH = 7,
   parameter int IN_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [IN_W-1:0]       s_data,
   input  logic                  s_last,
   input  logic [ADDR_WIDTH:0]   cfg_rows,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [TM*8-1:0]       wdata,
   output logic                  bank_sel_wr,
   output logic                  bank_sel_rd,
   output logic                  rd_bank_valid,
   input  logic                  rd_release,
   output logic                  tile_done,
   output logic                  err_last
);
   localparam int WPR = TM * 8 / IN_W;
   localparam int WCW = WPR > 1 ? $clog2(WPR) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(1) << ADDR_WIDTH;

   if ((TM * 8) % IN_W != 0) begin : g_bad_width
      $fatal(1, "act_buffer_loader: TM*8 must be a multiple of IN_W");
   end

   typedef enum logic [1:0] {IDLE, FILL, LAST, COMMIT} state_t;
   state_t state, state_n;
   logic [1:0] full;
   logic [WCW-1:0] word_cnt;
   logic [ADDR_WIDTH-1:0] row_cnt, last_row;
   logic accept, row_end, tile_end, release_ok;

   assign s_ready = state == FILL;
   assign tile_done = state == COMMIT;
   assign rd_bank_valid = full[bank_sel_rd];
   assign accept = s_valid && s_ready;
   assign row_end = word_cnt == WCW'(WPR - 1);
   assign tile_end = row_end && row_cnt == last_row;
   assign release_ok = rd_release && rd_bank_valid;

   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (full[bank_sel_wr] ? IDLE : FILL)
              : state == FILL ? (accept && tile_end ? LAST : FILL)
              : state == LAST ? COMMIT : IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= '0;
         word_cnt <= '0;
         row_cnt <= '0;
         last_row <= '0;
         we <= 1'b0;
         waddr <= '0;
         wdata <= '0;
         bank_sel_wr <= 1'b0;
         bank_sel_rd <= 1'b0;
         err_last <= 1'b0;
      end else begin
         we <= accept && row_end;
         // 0 and anything beyond the buffer depth both wrap to a full-depth tile
         if (state == IDLE && !full[bank_sel_wr]) begin
            last_row <= cfg_rows > DEPTH ? '1 : ADDR_WIDTH'(cfg_rows - (ADDR_WIDTH + 1)'(1));
            word_cnt <= '0;
            row_cnt <= '0;
         end
         if (accept) begin
            wdata[word_cnt * IN_W +: IN_W] <= s_data;
            word_cnt <= row_end ? '0 : word_cnt + WCW'(1);
            err_last <= err_last | (s_last != tile_end);
            if (row_end) begin
               waddr <= row_cnt;
               row_cnt <= row_cnt + ADDR_WIDTH'(1);
            end
         end
         if (state == COMMIT) bank_sel_wr <= !bank_sel_wr;
         if (release_ok) bank_sel_rd <= !bank_sel_rd;
         full <= (full & ~(release_ok ? 2'b01 << bank_sel_rd : 2'b00))
               | (state == COMMIT ? 2'b01 << bank_sel_wr : 2'b00);
      end
   end
endmodule

// File: tb/tb_act_buffer_loader.sv
// tb_act_buffer_loader: randomized word stream against a tile-level model; a
// scoreboard holds expected row writes and commits, a monitor compares them.
module tb_act_buffer_loader;
   localparam int TM = 8, AW = 2, IN_W = 32;
   localparam int RW = TM * 8, WPR = RW / IN_W, DEPTH = 1 << AW;

   logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_last = 1'b0, rd_release = 1'b0;
   logic [IN_W-1:0] s_data = '0;
   logic [AW:0] cfg_rows = 3;
   logic s_ready, we, bank_sel_wr, bank_sel_rd, rd_bank_valid, tile_done, err_last;
   logic [AW-1:0] waddr;
   logic [RW-1:0] wdata;

   int cyc = 0, errors = 0, checks = 0;
   logic [1:0] m_full = 2'b00;
   logic m_wr = 1'b0, m_rd = 1'b0;

   typedef struct {int cyc; logic bank; int addr; logic [RW-1:0] data;} wr_t;
   typedef struct {int cyc; logic bank;} cm_t;
   wr_t wq[$];
   cm_t cq[$];

   act_buffer_loader #(.TM(TM), .ADDR_WIDTH(AW), .IN_W(IN_W)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .cfg_rows(cfg_rows), .we(we), .waddr(waddr), .wdata(wdata),
      .bank_sel_wr(bank_sel_wr), .bank_sel_rd(bank_sel_rd), .rd_bank_valid(rd_bank_valid),
      .rd_release(rd_release), .tile_done(tile_done), .err_last(err_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      wr_t e;
      cm_t c;
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
         checks++; errors++;
         e = wq.pop_front();
         $display("FAIL we_missing: no write seen, expected addr %0d at cycle %0d", e.addr, e.cyc);
      end
      if (cq.size() > 0 && cq[0].cyc < cyc) begin
         checks++; errors++;
         c = cq.pop_front();
         $display("FAIL commit_missing: no tile_done seen, expected at cycle %0d", c.cyc);
      end
      if (we) begin
         if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL we_unexpected: waddr=%0d wdata=%h, expected no write", waddr, wdata);
         end else begin
            e = wq.pop_front();
            chk("we_cycle", cyc, e.cyc);
            chk("waddr", waddr, e.addr);
            chk("wdata", wdata, e.data);
            chk("we_bank", bank_sel_wr, e.bank);
         end
      end
      if (tile_done) begin
         if (cq.size() == 0) begin
            checks++; errors++;
            $display("FAIL tile_done_unexpected: bank_sel_wr=%0d, expected no commit", bank_sel_wr);
         end else begin
            c = cq.pop_front();
            chk("commit_cycle", cyc, c.cyc);
            chk("commit_bank", bank_sel_wr, c.bank);
         end
      end
   end

   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!s_ready && n < 40) begin
         n++;
         @(negedge clk);
      end
      if (!s_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_tile(input int cfg, input int nsend, input int la, input int lb,
                            input int gap_pct, input int stall1, input bit fixed);
      int rows;
      logic [RW-1:0] row;
      logic [IN_W-1:0] w;
      wr_t e;
      cm_t c;
      rows = (cfg == 0 || cfg > DEPTH) ? DEPTH : cfg;
      row = '0;
      for (int i = 0; i < nsend; i++) begin
         w = fixed ? IN_W'((i + 1) * 32'h11111111) : IN_W'($urandom);
         s_valid = 1'b1;
         s_data = w;
         s_last = (i == la || i == lb);
         wait_accept();
         row[(i % WPR) * IN_W +: IN_W] = w;
         if (i % WPR == WPR - 1) begin
            e.cyc = cyc; e.bank = m_wr; e.addr = i / WPR; e.data = row;
            wq.push_back(e);
         end
         if (i == rows * WPR - 1) begin
            c.cyc = cyc + 1; c.bank = m_wr;
            cq.push_back(c);
         end
         s_valid = 1'b0;
         s_last = 1'b0;
         if (i == 0 && stall1 > 0)
            repeat (stall1) begin @(posedge clk); #1; end
         else
            while ($urandom_range(99) < gap_pct) begin @(posedge clk); #1; end
      end
   endtask

   task automatic finish_tile();
      @(posedge clk); #1;
      chk("rbv_during_commit", rd_bank_valid, m_full[m_rd]);
      m_full[m_wr] = 1'b1;
      m_wr = ~m_wr;
      @(posedge clk); #1;
      chk("rbv_after_commit", rd_bank_valid, m_full[m_rd]);
      chk("bank_sel_rd", bank_sel_rd, m_rd);
      chk("bank_sel_wr", bank_sel_wr, m_wr);
   endtask

   task automatic release_bank();
      chk("rbv_before_release", rd_bank_valid, m_full[m_rd]);
      rd_release = 1'b1;
      @(posedge clk); #1;
      rd_release = 1'b0;
      if (m_full[m_rd]) begin
         m_full[m_rd] = 1'b0;
         m_rd = ~m_rd;
      end
      chk("bank_sel_rd_release", bank_sel_rd, m_rd);
      chk("rbv_after_release", rd_bank_valid, m_full[m_rd]);
   endtask

   task automatic check_reset();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_bank_sel_wr", bank_sel_wr, 0);
      chk("rst_bank_sel_rd", bank_sel_rd, 0);
      chk("rst_rd_bank_valid", rd_bank_valid, 0);
      chk("rst_tile_done", tile_done, 0);
      chk("rst_err_last", err_last, 0);
   endtask

   initial begin
      #500000;
      checks++; errors++;
      $display("FAIL watchdog: run still active at cycle %0d, required to have finished", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;
      release_bank();
      // basic tile with known words, then a second tile filling bank 1
      send_tile(3, 6, 5, -1, 0, 0, 1'b1);
      finish_tile();
      chk("err_last_clean", err_last, 0);
      send_tile(3, 6, 5, -1, 0, 0, 1'b0);
      finish_tile();
      s_valid = 1'b1;
      s_data = $urandom;
      repeat (6) begin
         @(negedge clk);
         chk("both_full_s_ready", s_ready, 0);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      release_bank();
      @(negedge clk);
      chk("refill_s_ready_r1", s_ready, 0);
      @(negedge clk);
      chk("refill_s_ready_r2", s_ready, 1);
      chk("refill_bank", bank_sel_wr, m_wr);
      @(posedge clk); #1;
      // commit of bank 0 coincides with release of bank 1
      send_tile(3, 6, 5, -1, 0, 0, 1'b0);
      @(posedge clk); #1;
      rd_release = 1'b1;
      @(posedge clk); #1;
      rd_release = 1'b0;
      m_full[m_wr] = 1'b1; m_wr = ~m_wr;
      m_full[m_rd] = 1'b0; m_rd = ~m_rd;
      chk("overlap_rbv", rd_bank_valid, m_full[m_rd]);
      chk("overlap_bank_sel_rd", bank_sel_rd, m_rd);
      chk("overlap_bank_sel_wr", bank_sel_wr, m_wr);
      repeat (2) @(negedge clk);
      chk("overlap_refill", s_ready, 1);
      @(posedge clk); #1;
      send_tile(3, 6, 5, -1, 30, 3, 1'b1);
      finish_tile();
      chk("err_last_gaps", err_last, 0);
      release_bank();
      send_tile(3, 6, 5, 2, 0, 0, 1'b0);
      finish_tile();
      chk("err_last_early", err_last, 1);
      cfg_rows = 0;
      release_bank();
      send_tile(0, 8, 7, -1, 20, 0, 1'b0);
      finish_tile();
      chk("err_last_sticky", err_last, 1);
      cfg_rows = 6;
      release_bank();
      send_tile(6, 8, 7, -1, 0, 0, 1'b0);
      finish_tile();
      cfg_rows = 3;
      release_bank();
      // reset in the middle of the second row with bank 0 still full
      send_tile(3, 3, 5, -1, 0, 0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset();
      rst = 1'b0;
      m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0;
      chk("queue_after_reset", wq.size() + cq.size(), 0);
      send_tile(3, 6, 5, -1, 10, 0, 1'b0);
      finish_tile();
      chk("err_last_after_reset", err_last, 0);
      send_tile(3, 6, -1, -1, 0, 0, 1'b0);
      finish_tile();
      chk("err_last_missing", err_last, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("writes_pending", wq.size(), 0);
      chk("commits_pending", cq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
